// File: rtl/stall_buffer_fifo_if.sv
// stall_buffer_fifo_if
// Handshake/bus bundle between the upstream pipeline register (master) and
// the stall buffer (slave).
//   flush        : synchronous clear request (mispredict / exception recovery)
//   inputs, enq  : enqueue data and request
//   deq          : dequeue request (pops the word currently on outputs)
//   outputs      : head entry, zero when empty
//   buffer_empty, buffer_full, almost_full, count : occupancy status
//   overflow, underflow : sticky error flags
interface stall_buffer_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic [WIDTH-1:0] inputs;
    logic             enq;
    logic             deq;
    logic [WIDTH-1:0] outputs;
    logic             buffer_empty;
    logic             buffer_full;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, inputs, enq, deq,
        input  outputs, buffer_empty, buffer_full, almost_full, count,
               overflow, underflow
    );

    modport slave (
        input  flush, inputs, enq, deq,
        output outputs, buffer_empty, buffer_full, almost_full, count,
               overflow, underflow
    );
endinterface

// File: rtl/stall_buffer_fifo.sv
// stall_buffer_fifo
// First-word-fall-through FIFO holding instructions/operands while the
// downstream stage stalls. Circular pointers wrap explicitly, so DEPTH need
// not be a power of two.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear of all state
//   bus   : stall_buffer_fifo_if slave modport (data, handshake, status)
module stall_buffer_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic               clk,
    input  logic               reset,
    stall_buffer_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             underflow_q;

    logic is_empty;
    logic is_full;
    logic do_enq;
    logic do_deq;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // When full, a simultaneous deq frees the slot the enq writes into.
    assign do_enq = bus.enq && (!is_full || bus.deq);
    assign do_deq = bus.deq && !is_empty;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (do_deq) begin
                mem[rd_ptr] <= '0;
                rd_ptr      <= next_ptr(rd_ptr);
            end
            // Placed after the clear so that at full (wr_ptr == rd_ptr)
            // the new word wins over the zeroing of the popped slot.
            if (do_enq) begin
                mem[wr_ptr] <= bus.inputs;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_enq && !do_deq)
                count_q <= count_q + CW'(1);
            else if (do_deq && !do_enq)
                count_q <= count_q - CW'(1);
            if (bus.enq && !do_enq)
                overflow_q <= 1'b1;
            if (bus.deq && !do_deq)
                underflow_q <= 1'b1;
        end
    end

    assign bus.outputs      = is_empty ? '0 : mem[rd_ptr];
    assign bus.buffer_empty = is_empty;
    assign bus.buffer_full  = is_full;
    assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_stall_buffer_fifo.sv
module tb_stall_buffer_fifo;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int THRESH = DEPTH - 1;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    stall_buffer_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stall_buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(THRESH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of stored words plus two sticky bits.
    logic [WIDTH-1:0] m_q [$];
    logic             m_of;
    logic             m_uf;

    always @(posedge clk or posedge reset) begin
        if (reset || bus.flush) begin
            m_q.delete();
            m_of = 1'b0;
            m_uf = 1'b0;
        end else begin
            automatic bit was_full  = (m_q.size() == DEPTH);
            automatic bit was_empty = (m_q.size() == 0);
            if (bus.deq && was_empty) m_uf = 1'b1;
            if (bus.enq && was_full && !bus.deq) m_of = 1'b1;
            if (bus.deq && !was_empty) void'(m_q.pop_front());
            if (bus.enq && (!was_full || bus.deq)) m_q.push_back(bus.inputs);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!reset) begin
            automatic int n = m_q.size();
            check("m_outputs", 64'(bus.outputs), (n > 0) ? 64'(m_q[0]) : 64'd0);
            check("m_count", 64'(bus.count), 64'(n));
            check("m_empty", 64'(bus.buffer_empty), 64'(n == 0));
            check("m_full", 64'(bus.buffer_full), 64'(n == DEPTH));
            check("m_afull", 64'(bus.almost_full), 64'(n >= THRESH));
            check("m_overflow", 64'(bus.overflow), 64'(m_of));
            check("m_underflow", 64'(bus.underflow), 64'(m_uf));
        end
    end

    // Apply one cycle of stimulus; returns at the following falling edge.
    task automatic cyc(input bit e, input bit d, input bit f, input logic [WIDTH-1:0] data);
        bus.enq    = e;
        bus.deq    = d;
        bus.flush  = f;
        bus.inputs = data;
        @(posedge clk);
        @(negedge clk);
        bus.enq   = 1'b0;
        bus.deq   = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        bus.enq = 1'b0;
        bus.deq = 1'b0;
        bus.flush  = 1'b0;
        bus.inputs = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_empty", 64'(bus.buffer_empty), 64'd1);
        check("rst_outputs", 64'(bus.outputs), 64'd0);

        // Fill
        cyc(1, 0, 0, 32'hA0);
        check("fill1_count", 64'(bus.count), 64'd1);
        check("fill1_out", 64'(bus.outputs), 64'hA0);
        check("fill1_afull", 64'(bus.almost_full), 64'd0);
        cyc(1, 0, 0, 32'hA1);
        check("fill2_count", 64'(bus.count), 64'd2);
        cyc(1, 0, 0, 32'hA2);
        check("fill3_afull", 64'(bus.almost_full), 64'd1);
        check("fill3_full", 64'(bus.buffer_full), 64'd0);
        cyc(1, 0, 0, 32'hA3);
        check("fill4_full", 64'(bus.buffer_full), 64'd1);
        check("fill4_out", 64'(bus.outputs), 64'hA0);
        cyc(1, 0, 0, 32'hA4);
        check("ovf_flag", 64'(bus.overflow), 64'd1);
        check("ovf_count", 64'(bus.count), 64'd4);

        // Drain with wrap
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("drain_head", 64'(bus.outputs), 64'hA2);
        cyc(1, 0, 0, 32'hB0);
        cyc(1, 0, 0, 32'hB1);
        check("wrap_count", 64'(bus.count), 64'd4);
        check("wrap_head", 64'(bus.outputs), 64'hA2);
        cyc(0, 1, 0, 0);
        check("wrap_d1", 64'(bus.outputs), 64'hA3);
        cyc(0, 1, 0, 0);
        check("wrap_d2", 64'(bus.outputs), 64'hB0);
        cyc(0, 1, 0, 0);
        check("wrap_d3", 64'(bus.outputs), 64'hB1);
        cyc(0, 1, 0, 0);
        check("wrap_d4", 64'(bus.outputs), 64'h0);
        check("wrap_empty", 64'(bus.buffer_empty), 64'd1);
        check("wrap_uf_pre", 64'(bus.underflow), 64'd0);
        cyc(0, 1, 0, 0);
        check("udf_flag", 64'(bus.underflow), 64'd1);
        check("udf_ovf_sticky", 64'(bus.overflow), 64'd1);
        cyc(0, 0, 1, 0);
        check("flush_ovf", 64'(bus.overflow), 64'd0);

        // Simultaneous enq+deq at full
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'hC0 + 32'(i));
        cyc(1, 1, 0, 32'hC4);
        check("sim_full_count", 64'(bus.count), 64'd4);
        check("sim_full_ovf", 64'(bus.overflow), 64'd0);
        check("sim_full_head", 64'(bus.outputs), 64'hC1);
        cyc(0, 1, 0, 0);
        check("sim_d1", 64'(bus.outputs), 64'hC2);
        cyc(0, 1, 0, 0);
        check("sim_d2", 64'(bus.outputs), 64'hC3);
        cyc(0, 1, 0, 0);
        check("sim_d3", 64'(bus.outputs), 64'hC4);
        cyc(0, 1, 0, 0);
        check("sim_d4", 64'(bus.outputs), 64'h0);

        // Simultaneous enq+deq when empty
        cyc(1, 1, 0, 32'hD0);
        check("sim_empty_count", 64'(bus.count), 64'd1);
        check("sim_empty_uf", 64'(bus.underflow), 64'd1);
        check("sim_empty_out", 64'(bus.outputs), 64'hD0);

        // Flush with pending traffic: 3 entries, both flags set
        cyc(1, 0, 0, 32'hD1);
        cyc(1, 0, 0, 32'hD2);
        cyc(1, 0, 0, 32'hD3);
        cyc(1, 0, 0, 32'hD4);
        cyc(0, 1, 0, 0);
        check("pre_flush_count", 64'(bus.count), 64'd3);
        check("pre_flush_ovf", 64'(bus.overflow), 64'd1);
        cyc(1, 1, 1, 32'hFF);
        check("flush_count", 64'(bus.count), 64'd0);
        check("flush_out", 64'(bus.outputs), 64'd0);
        check("flush_of", 64'(bus.overflow), 64'd0);
        check("flush_uf", 64'(bus.underflow), 64'd0);
        check("flush_empty", 64'(bus.buffer_empty), 64'd1);

        // Async reset mid-stream
        cyc(1, 0, 0, 32'hE1);
        cyc(1, 1, 0, 32'hE2);
        cyc(1, 0, 0, 32'hE3);
        cyc(1, 0, 0, 32'hE4);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 32'hE5);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("pre_rst_count", 64'(bus.count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", 64'(bus.count), 64'd0);
        check("arst_out", 64'(bus.outputs), 64'd0);
        check("arst_empty", 64'(bus.buffer_empty), 64'd1);
        check("arst_uf", 64'(bus.underflow), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 0, 32'hE0);
        check("post_rst_out", 64'(bus.outputs), 64'hE0);
        check("post_rst_count", 64'(bus.count), 64'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            automatic bit e = ($urandom_range(0, 99) < 55);
            automatic bit d = ($urandom_range(0, 99) < 45);
            automatic bit f = ($urandom_range(0, 99) < 2);
            cyc(e, d, f, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/stall_buffer_fifo.md
# stall_buffer_fifo

Parametrised stall buffer for the pipelined datapath: a first-word-fall-through FIFO of DEPTH entries, each WIDTH bits, that holds instructions/operands while a downstream stage is stalled. It supersedes the fixed two-slot stall buffer. New capabilities: arbitrary depth with circular pointers, simultaneous enqueue and dequeue, an occupancy count, an almost-full early-stall flag, and sticky overflow/underflow error flags. It sits between an upstream pipeline register and the stalling stage; flush is driven by branch-mispredict or exception recovery.

## Interface
- WIDTH, 32, data width in bits (>= 1)
- DEPTH, 4, number of entries (>= 2; need not be a power of two)
- AFULL_THRESH, DEPTH-1, almost_full asserts when count >= AFULL_THRESH (1..DEPTH)
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- flush  input  1  synchronous clear of contents, pointers, count and error flags
- inputs  input  WIDTH  enqueue data
- enq  input  1  enqueue request
- deq  input  1  dequeue request (pops the entry currently on outputs)
- outputs  output  WIDTH  head entry (FWFT); all-zero when empty
- buffer_empty  output  1  count == 0
- buffer_full  output  1  count == DEPTH
- almost_full  output  1  count >= AFULL_THRESH
- count  output  $clog2(DEPTH+1)  number of valid entries
- overflow  output  1  sticky: an enq was dropped
- underflow  output  1  sticky: a deq was ignored

## Operation
- Storage: DEPTH x WIDTH array; wr_ptr and rd_ptr range over 0..DEPTH-1. Each pointer increments by one and wraps from DEPTH-1 to 0. The design never relies on power-of-two wrap.
- Priority per cycle: reset > flush > enq/deq.
- flush: zero all entries, zero both pointers and count, clear overflow/underflow. Any enq/deq in the same cycle is ignored and sets no flag.
- Accepted enq: mem[wr_ptr] <= inputs, advance wr_ptr.
- Accepted deq: mem[rd_ptr] <= 0, advance rd_ptr.
- Acceptance rules, decided on pre-edge state:
  - enq only, not full: accepted, count +1.
  - enq only, full: dropped, overflow <= 1, no state change.
  - deq only, not empty: accepted, count -1.
  - deq only, empty: ignored, underflow <= 1.
  - enq+deq, 0 < count < DEPTH: both accepted, count unchanged.
  - enq+deq, full: both accepted. The head is popped and the new word is written into the freed slot (wr_ptr == rd_ptr before the edge). count stays DEPTH, no overflow.
  - enq+deq, empty: enq accepted, deq ignored, underflow <= 1, count becomes 1. There is no bypass: the new word appears on outputs the next cycle.
- outputs = buffer_empty ? 0 : mem[rd_ptr]. This is combinational from registered state, with no path from inputs/enq/deq.
- buffer_empty, buffer_full, almost_full are combinational decodes of count only.
- overflow/underflow stay set until flush or reset.

## Timing
- Reset values: outputs=0, count=0, buffer_empty=1, buffer_full=0, almost_full=0, overflow=0, underflow=0, all entries and pointers 0.
- Reset assertion takes effect without a clock edge. The first update after deassertion happens on the next rising clk edge.
- Reset mid-operation discards all contents; no partial writes survive.
- Enqueue-to-output latency: 1 cycle when empty, i.e. data is visible on outputs after the edge that accepts it.
- count, flags and outputs update on the same edge as the accepted operation. The error flags set on the edge of the offending request.
- A dequeue is a pop on the clock edge. outputs shows the next entry (or 0) after that edge.
- Upstream must use buffer_full/almost_full from the current cycle to gate enq. Downstream must use buffer_empty to gate deq. Violations are tolerated and flagged, never corrupt state.

## Test plan
- Reset then fill, DEPTH=4: enq 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
  - count goes 1,2,3,4; almost_full rises at count 3; buffer_full at 4; outputs=0xA0 throughout.
  - A fifth enq of 0xA4 sets overflow and leaves count=4.
- Drain with wrap: from the full state, deq x2, then enq 0xB0,0xB1 (wr_ptr wraps to 0), then deq x4.
  - outputs sequence is 0xA2,0xA3,0xB0,0xB1, then 0; buffer_empty=1.
  - One extra deq sets underflow.
- Simultaneous enq+deq at full: with 0xC0..0xC3 stored, assert enq=1 (0xC4) and deq=1.
  - count stays 4, overflow stays 0.
  - The following four deqs yield 0xC1,0xC2,0xC3,0xC4.
- Simultaneous enq+deq when empty: enq 0xD0 with deq=1.
  - count=1, underflow=1, outputs=0xD0 after the edge.
- Flush with pending traffic: with 3 entries and both error flags set, assert flush together with enq and deq.
  - Next cycle: count=0, outputs=0, overflow=0, underflow=0, buffer_empty=1.
- Async reset mid-stream: assert reset between clock edges with 2 entries held.
  - All outputs reach reset values before the next edge.
  - Enq 0xE0 after release gives outputs=0xE0, count=1.
